// File: rtl/placar_pkg.sv
// Shared definitions for the scoreboard score keeper: widths, default limits,
// point values, FSM state encoding and the latched-press record.
package placar_pkg;

  localparam int LARG_PONTOS = 7;

  localparam int MAX_PONTOS_PADRAO      = 99;
  localparam int DEBOUNCE_CICLOS_PADRAO = 4;
  localparam int BUZZER_CICLOS_PADRAO   = 8;

  localparam logic [1:0] PONTO_A = 2'd1;
  localparam logic [1:0] PONTO_B = 2'd2;
  localparam logic [1:0] PONTO_C = 2'd3;

  typedef enum logic [1:0] {
    OCIOSO,
    CAPTURA,
    APLICAR,
    ESPERA_SOLTAR
  } estado_t;

  // Everything sampled at the moment a press is accepted.
  typedef struct packed {
    logic [1:0] valor;
    logic       time2;
    logic       subtrair;
  } jogada_t;

  // Number of buttons currently high, saturating is unnecessary for three inputs.
  function automatic logic [1:0] conta_ativos(input logic [2:0] v);
    conta_ativos = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// One raw push button: two-flop synchronizer, stability counter and a
// single-cycle pulse in the cycle before the debounced level rises.
module debounce_botao #(
  parameter int CICLOS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bruto,
  output logic nivel,
  output logic pulso
);

  localparam int LARG_CNT = ($clog2(CICLOS) > 0) ? $clog2(CICLOS) : 1;

  logic                sinc1;
  logic                sinc2;
  logic [LARG_CNT-1:0] cnt;
  logic                estavel;

  // The synced sample has disagreed with the level for CICLOS cycles running.
  assign estavel = (cnt == LARG_CNT'(CICLOS - 1));
  // Announces the rising edge one cycle early so the FSM latches it in the
  // same clock that the debounced level goes high.
  assign pulso   = sinc2 & ~nivel & estavel;

  // Synchronize, then flip the level only after a run of equal samples.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every flop sample the pre-edge values,
    // which is what makes sinc1 -> sinc2 a real two-stage pipeline.
    if (reset) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
      cnt   <= '0;
      nivel <= 1'b0;
    end else begin
      sinc1 <= bruto;
      sinc2 <= sinc1;
      if (sinc2 == nivel) begin
        cnt <= '0;
      end else if (estavel) begin
        nivel <= sinc2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/placar_registro_pontos.sv
// Score keeper for the basketball scoreboard: debounces the point buttons,
// applies exactly one add/subtract per press to the selected team and flags
// rejected operations on led_invalido and a fixed-length buzzer pulse.
// Optional feature: define PLACAR_ZERAR_EN to add the debounced `zerar`
// input, which clears both scores from OCIOSO with priority over A/B/C.
module placar_registro_pontos
  import placar_pkg::*;
#(
  parameter int MAX_PONTOS      = MAX_PONTOS_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int BUZZER_CICLOS   = BUZZER_CICLOS_PADRAO
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   A,
  input  logic                   B,
  input  logic                   C,
  input  logic                   ChaveNegativaPositiva,
  input  logic                   MudarTime,
`ifdef PLACAR_ZERAR_EN
  input  logic                   zerar,
`endif
  output logic [LARG_PONTOS-1:0] pontos_time1,
  output logic [LARG_PONTOS-1:0] pontos_time2,
  output logic                   led_invalido,
  output logic                   buzzer
);

  localparam int LARG_BUZ = $clog2(BUZZER_CICLOS + 1);

  logic [2:0] nivel_bt;
  logic [2:0] pulso_bt;
  logic [2:0] ativos;
  logic       nivel_zerar;
  logic       pulso_zerar;

  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_deb_a (
    .clk(clk), .reset(reset), .bruto(A), .nivel(nivel_bt[0]), .pulso(pulso_bt[0])
  );
  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_deb_b (
    .clk(clk), .reset(reset), .bruto(B), .nivel(nivel_bt[1]), .pulso(pulso_bt[1])
  );
  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_deb_c (
    .clk(clk), .reset(reset), .bruto(C), .nivel(nivel_bt[2]), .pulso(pulso_bt[2])
  );

`ifdef PLACAR_ZERAR_EN
  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_deb_zerar (
    .clk(clk), .reset(reset), .bruto(zerar), .nivel(nivel_zerar), .pulso(pulso_zerar)
  );
`else
  assign nivel_zerar = 1'b0;
  assign pulso_zerar = 1'b0;
`endif

  // A button counts as held from the cycle its rising edge is announced.
  assign ativos = nivel_bt | pulso_bt;

  estado_t                estado;
  estado_t                prox_estado;
  jogada_t                jogada;
  logic [LARG_PONTOS-1:0] lido;
  logic [LARG_BUZ-1:0]    buz_cnt;

  logic                   carregar;
  logic                   ler;
  logic                   gravar;
  logic                   rejeitar;
  logic                   zerar_tudo;
  logic [1:0]             valor_press;

  // Arithmetic is checked one bit wider than the score so nothing wraps.
  logic [LARG_PONTOS:0]   lido_ext;
  logic [LARG_PONTOS:0]   valor_ext;
  logic [LARG_PONTOS:0]   soma;
  logic                   op_valida;
  logic [LARG_PONTOS-1:0] resultado;

  assign lido_ext  = {1'b0, lido};
  assign valor_ext = {{(LARG_PONTOS - 1){1'b0}}, jogada.valor};
  assign soma      = lido_ext + valor_ext;
  assign op_valida = jogada.subtrair ? (valor_ext <= lido_ext)
                                     : (soma <= (LARG_PONTOS + 1)'(MAX_PONTOS));
  assign resultado = jogada.subtrair ? (lido - LARG_PONTOS'(jogada.valor))
                                     : (lido + LARG_PONTOS'(jogada.valor));

  assign buzzer    = (buz_cnt != '0);

  // Point value of the single button being pressed.
  always_comb begin
    unique case (pulso_bt)
      3'b010:  valor_press = PONTO_B;
      3'b100:  valor_press = PONTO_C;
      default: valor_press = PONTO_A;
    endcase
  end

  // Next state and one-cycle control strobes for the datapath.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    prox_estado = estado;
    carregar    = 1'b0;
    ler         = 1'b0;
    gravar      = 1'b0;
    rejeitar    = 1'b0;
    zerar_tudo  = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (pulso_zerar) begin
          zerar_tudo  = 1'b1;
          prox_estado = ESPERA_SOLTAR;
        end else if (pulso_bt != '0) begin
          if (conta_ativos(ativos) == 2'd1) begin
            carregar    = 1'b1;
            prox_estado = CAPTURA;
          end else begin
            rejeitar    = 1'b1;
            prox_estado = ESPERA_SOLTAR;
          end
        end
      end
      CAPTURA: begin
        ler         = 1'b1;
        prox_estado = APLICAR;
      end
      APLICAR: begin
        if (op_valida) gravar   = 1'b1;
        else           rejeitar = 1'b1;
        prox_estado = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (ativos == '0 && !nivel_zerar && !pulso_zerar) prox_estado = OCIOSO;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  // Latch the press parameters, then snapshot the selected team's score.
  always_ff @(posedge clk) begin
    if (reset) begin
      jogada <= '0;
      lido   <= '0;
    end else begin
      if (carregar) jogada <= '{valor: valor_press, time2: MudarTime,
                                subtrair: ChaveNegativaPositiva};
      if (ler)      lido   <= jogada.time2 ? pontos_time2 : pontos_time1;
    end
  end

  // Score registers; only the latched team is ever written.
  always_ff @(posedge clk) begin
    if (reset || zerar_tudo) begin
      pontos_time1 <= '0;
      pontos_time2 <= '0;
    end else if (gravar) begin
      if (jogada.time2) pontos_time2 <= resultado;
      else              pontos_time1 <= resultado;
    end
  end

  // Invalid-operation LED: set on rejection, cleared by an accepted update.
  always_ff @(posedge clk) begin
    if (reset || zerar_tudo) led_invalido <= 1'b0;
    else if (rejeitar)       led_invalido <= 1'b1;
    else if (gravar)         led_invalido <= 1'b0;
  end

  // Buzzer countdown; a new rejection restarts the full pulse.
  always_ff @(posedge clk) begin
    if (reset || zerar_tudo)  buz_cnt <= '0;
    else if (rejeitar)        buz_cnt <= LARG_BUZ'(BUZZER_CICLOS);
    else if (buz_cnt != '0)   buz_cnt <= buz_cnt - 1'b1;
  end

endmodule
